// File: rtl/ring_router_mux.sv
// ring_router_mux: output-side arbiter of a ring router station.
// Merges pass-through ring worms and locally injected worms onto the
// outgoing ring link. Whole worms are granted (first..last), never
// interleaved. A ring burst limit bounds how long a waiting local worm can
// be starved. The datapath is purely combinational (zero latency).
// Optional statistics counters are enabled with the macro
// RING_ROUTER_MUX_STATS_EN. Arbitration is the same with or without it.
module ring_router_mux #(
    parameter int MAX_RING_BURST = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          in_ring_data,
    input  logic                 in_ring_first,
    input  logic                 in_ring_last,
    input  logic                 in_ring_valid,
    output logic                 in_ring_ready,
    input  logic [15:0]          in_local_data,
    input  logic                 in_local_first,
    input  logic                 in_local_last,
    input  logic                 in_local_valid,
    output logic                 in_local_ready,
    output logic [15:0]          out_ring_data,
    output logic                 out_ring_first,
    output logic                 out_ring_last,
    output logic                 out_ring_valid,
    input  logic                 out_ring_ready
`ifdef RING_ROUTER_MUX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stat_ring_worms,
    output logic [CNT_WIDTH-1:0] stat_local_worms,
    output logic [CNT_WIDTH-1:0] stat_local_forced
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FWD_RING  = 2'd1,
        FWD_LOCAL = 2'd2
    } state_t;

    localparam int STREAK_W = (MAX_RING_BURST < 1) ? 1 : $clog2(MAX_RING_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(MAX_RING_BURST);
    localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(32'd1);
    localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};
    localparam bit GUARD_EN = (MAX_RING_BURST != 0);

    // Reject configurations that cannot work at elaboration time.
    generate
        if ((MAX_RING_BURST < 0) || (CNT_WIDTH < 1)) begin : g_bad_params
            $error("ring_router_mux: MAX_RING_BURST must be >= 0 and CNT_WIDTH >= 1");
        end
    endgenerate

    state_t              state_r;
    state_t              state_nxt_s;
    logic [STREAK_W-1:0] ring_streak_r;
    logic [STREAK_W-1:0] streak_nxt_s;
    logic                guard_s;
    logic                forced_s;
    logic                sel_local_s;
    logic                xfer_s;
    logic                worm_done_s;

    // Source selection: arbitrate only in IDLE, stay locked inside a worm.
    always_comb begin
        guard_s     = 1'b0;
        forced_s    = 1'b0;
        sel_local_s = 1'b0;
        if (GUARD_EN && (ring_streak_r >= STREAK_MAX)) begin
            guard_s = 1'b1;
        end else begin
            guard_s = 1'b0;
        end
        case (state_r)
            IDLE: begin
                forced_s    = in_local_valid & in_ring_valid & guard_s;
                sel_local_s = (in_local_valid & ~in_ring_valid) | forced_s;
            end
            FWD_RING:  sel_local_s = 1'b0;
            FWD_LOCAL: sel_local_s = 1'b1;
            default:   sel_local_s = 1'b0;
        endcase
    end

    // Zero-latency datapath. Reset masks valid/ready at once.
    always_comb begin
        out_ring_data  = in_ring_data;
        out_ring_first = in_ring_first;
        out_ring_last  = in_ring_last;
        out_ring_valid = 1'b0;
        in_ring_ready  = 1'b0;
        in_local_ready = 1'b0;
        if (sel_local_s) begin
            out_ring_data  = in_local_data;
            out_ring_first = in_local_first;
            out_ring_last  = in_local_last;
            out_ring_valid = in_local_valid & ~rst;
            in_local_ready = out_ring_ready & ~rst;
        end else begin
            out_ring_valid = in_ring_valid & ~rst;
            in_ring_ready  = out_ring_ready & ~rst;
        end
    end

    assign xfer_s = out_ring_valid & out_ring_ready;

    // Next-state and ring streak update on worm boundaries.
    always_comb begin
        state_nxt_s  = state_r;
        streak_nxt_s = ring_streak_r;
        worm_done_s  = xfer_s & out_ring_last;
        case (state_r)
            IDLE: begin
                if (xfer_s && !out_ring_last) begin
                    state_nxt_s = sel_local_s ? FWD_LOCAL : FWD_RING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FWD_RING, FWD_LOCAL: begin
                if (worm_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        if (worm_done_s) begin
            if (sel_local_s) begin
                streak_nxt_s = STREAK_ZERO;
            end else if (in_local_valid) begin
                if (ring_streak_r != STREAK_MAX) begin
                    streak_nxt_s = ring_streak_r + STREAK_ONE;
                end else begin
                    streak_nxt_s = ring_streak_r;
                end
            end else begin
                streak_nxt_s = STREAK_ZERO;
            end
        end else begin
            streak_nxt_s = ring_streak_r;
        end
    end

    // State register and ring streak counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            ring_streak_r <= STREAK_ZERO;
        end else begin
            state_r       <= state_nxt_s;
            ring_streak_r <= streak_nxt_s;
        end
    end

`ifdef RING_ROUTER_MUX_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(32'd1);

    // Saturating worm and forced-grant statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ring_worms   <= {CNT_WIDTH{1'b0}};
            stat_local_worms  <= {CNT_WIDTH{1'b0}};
            stat_local_forced <= {CNT_WIDTH{1'b0}};
        end else begin
            if (worm_done_s && !sel_local_s && (stat_ring_worms != CNT_MAX)) begin
                stat_ring_worms <= stat_ring_worms + CNT_ONE;
            end
            if (worm_done_s && sel_local_s && (stat_local_worms != CNT_MAX)) begin
                stat_local_worms <= stat_local_worms + CNT_ONE;
            end
            if ((state_r == IDLE) && forced_s && xfer_s && (stat_local_forced != CNT_MAX)) begin
                stat_local_forced <= stat_local_forced + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ring_router_mux.sv
// Self-checking bench for ring_router_mux. Two instances share the input
// stimulus: one with a ring burst limit of 2, one with strict ring priority.
// A scoreboard queue holds the expected output flit order.
module tb_ring_router_mux;

    typedef struct packed {
        logic [15:0] d;
        logic        f;
        logic        l;
    } flit_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_ring_data, in_local_data;
    logic        in_ring_first, in_ring_last, in_ring_valid;
    logic        in_local_first, in_local_last, in_local_valid;
    logic        out_ring_ready;

    logic [15:0] o2_data, o0_data;
    logic        o2_first, o2_last, o2_valid, o0_first, o0_last, o0_valid;
    logic        r2_ring_ready, r2_local_ready, r0_ring_ready, r0_local_ready;
`ifdef RING_ROUTER_MUX_STATS_EN
    logic [15:0] s2_ring, s2_local, s2_forced, s0_ring, s0_local, s0_forced;
`endif

    bit          use0;
    logic [15:0] m_data;
    logic        m_first, m_last, m_valid, m_ring_ready, m_local_ready;

    flit_t rq[$];
    flit_t lq[$];
    flit_t exp_q[$];
    bit    local_gap;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic        s_ring_ready, s_local_ready, s_out_valid, s_xfer;
    logic [15:0] s_data;

    always #5 clk = ~clk;

    ring_router_mux #(.MAX_RING_BURST(2), .CNT_WIDTH(16)) dut2 (
        .clk(clk), .rst(rst),
        .in_ring_data(in_ring_data), .in_ring_first(in_ring_first),
        .in_ring_last(in_ring_last), .in_ring_valid(in_ring_valid),
        .in_ring_ready(r2_ring_ready),
        .in_local_data(in_local_data), .in_local_first(in_local_first),
        .in_local_last(in_local_last), .in_local_valid(in_local_valid),
        .in_local_ready(r2_local_ready),
        .out_ring_data(o2_data), .out_ring_first(o2_first),
        .out_ring_last(o2_last), .out_ring_valid(o2_valid),
        .out_ring_ready(out_ring_ready)
`ifdef RING_ROUTER_MUX_STATS_EN
        , .stat_ring_worms(s2_ring), .stat_local_worms(s2_local),
        .stat_local_forced(s2_forced)
`endif
    );

    ring_router_mux #(.MAX_RING_BURST(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst),
        .in_ring_data(in_ring_data), .in_ring_first(in_ring_first),
        .in_ring_last(in_ring_last), .in_ring_valid(in_ring_valid),
        .in_ring_ready(r0_ring_ready),
        .in_local_data(in_local_data), .in_local_first(in_local_first),
        .in_local_last(in_local_last), .in_local_valid(in_local_valid),
        .in_local_ready(r0_local_ready),
        .out_ring_data(o0_data), .out_ring_first(o0_first),
        .out_ring_last(o0_last), .out_ring_valid(o0_valid),
        .out_ring_ready(out_ring_ready)
`ifdef RING_ROUTER_MUX_STATS_EN
        , .stat_ring_worms(s0_ring), .stat_local_worms(s0_local),
        .stat_local_forced(s0_forced)
`endif
    );

    assign m_data        = use0 ? o0_data        : o2_data;
    assign m_first       = use0 ? o0_first       : o2_first;
    assign m_last        = use0 ? o0_last        : o2_last;
    assign m_valid       = use0 ? o0_valid       : o2_valid;
    assign m_ring_ready  = use0 ? r0_ring_ready  : r2_ring_ready;
    assign m_local_ready = use0 ? r0_local_ready : r2_local_ready;

    function automatic flit_t fl(input logic [15:0] d, input logic f, input logic l);
        flit_t x;
        x.d = d; x.f = f; x.l = l;
        return x;
    endfunction

    task automatic drive_sources();
        if (rq.size() > 0) begin
            in_ring_valid = 1'b1;
            {in_ring_data, in_ring_first, in_ring_last} = rq[0];
        end else begin
            in_ring_valid = 1'b0;
            {in_ring_data, in_ring_first, in_ring_last} = 18'd0;
        end
        if (lq.size() > 0 && !local_gap) begin
            in_local_valid = 1'b1;
            {in_local_data, in_local_first, in_local_last} = lq[0];
        end else begin
            in_local_valid = 1'b0;
            {in_local_data, in_local_first, in_local_last} = 18'd0;
        end
    endtask

    // One clock cycle: sample at negedge, score the output flit, advance sources.
    task automatic step();
        flit_t e;
        flit_t junk;
        logic  r_x, l_x;
        @(negedge clk);
        s_ring_ready  = m_ring_ready;
        s_local_ready = m_local_ready;
        s_out_valid   = m_valid;
        s_xfer        = m_valid & out_ring_ready;
        s_data        = m_data;
        if (s_xfer) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected cyc=%0d got=%h expected=none", cyc, m_data);
            end else begin
                e = exp_q.pop_front();
                if ({m_data, m_first, m_last} !== e) begin
                    failures++;
                    $display("FAIL sb_flit cyc=%0d got=%h/%b/%b expected=%h/%b/%b",
                             cyc, m_data, m_first, m_last, e.d, e.f, e.l);
                end
            end
        end
        r_x = in_ring_valid & m_ring_ready;
        l_x = in_local_valid & m_local_ready;
        @(posedge clk);
        #1;
        if (r_x) junk = rq.pop_front();
        if (l_x) junk = lq.pop_front();
        cyc++;
        drive_sources();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rq.delete(); lq.delete(); exp_q.delete();
        local_gap = 1'b0;
        out_ring_ready = 1'b1;
        drive_sources();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        use0 = 1'b0;
        rst = 1'b1;
        out_ring_ready = 1'b1;
        rq.delete(); lq.delete(); exp_q.delete();
        rq.push_back(fl(16'h0F0F, 1'b1, 1'b1));
        drive_sources();
        @(negedge clk);
        checks++;
        if (o2_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b expected=0", o2_valid); end
        checks++;
        if (r2_ring_ready !== 1'b0) begin failures++; $display("FAIL rst_ring_ready got=%b expected=0", r2_ring_ready); end
        checks++;
        if (r2_local_ready !== 1'b0) begin failures++; $display("FAIL rst_local_ready got=%b expected=0", r2_local_ready); end
        rq.delete();
        drive_sources();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_ring_ready !== 1'b1) begin failures++; $display("FAIL idle_ring_ready got=%b expected=1", m_ring_ready); end
        checks++;
        if (m_local_ready !== 1'b0) begin failures++; $display("FAIL idle_local_ready got=%b expected=0", m_local_ready); end
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b expected=0", m_valid); end
    endtask

    task automatic test_local_only();
        use0 = 1'b0;
        do_reset();
        lq.push_back(fl(16'h0005, 1'b1, 1'b0));
        lq.push_back(fl(16'hAAAA, 1'b0, 1'b0));
        lq.push_back(fl(16'hBBBB, 1'b0, 1'b1));
        foreach (lq[i]) exp_q.push_back(lq[i]);
        drive_sources();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (s_xfer !== 1'b1) begin failures++; $display("FAIL local_contig cyc=%0d got=%b expected=1", i, s_xfer); end
            checks++;
            if (s_ring_ready !== 1'b0) begin failures++; $display("FAIL local_ring_blocked cyc=%0d got=%b expected=0", i, s_ring_ready); end
        end
        rq.push_back(fl(16'h0123, 1'b1, 1'b1));
        exp_q.push_back(fl(16'h0123, 1'b1, 1'b1));
        drive_sources();
        step();
        checks++;
        if (s_ring_ready !== 1'b1 || s_xfer !== 1'b1) begin
            failures++;
            $display("FAIL local_back_idle got=%b%b expected=11", s_ring_ready, s_xfer);
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL local_drain got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_interleave();
        int l0_cyc;
        use0 = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rq.push_back(fl(16'h1000 + 16'(i), (i == 0), (i == 3)));
            exp_q.push_back(fl(16'h1000 + 16'(i), (i == 0), (i == 3)));
        end
        drive_sources();
        step();
        lq.push_back(fl(16'h2000, 1'b1, 1'b0));
        lq.push_back(fl(16'h2001, 1'b0, 1'b1));
        exp_q.push_back(fl(16'h2000, 1'b1, 1'b0));
        exp_q.push_back(fl(16'h2001, 1'b0, 1'b1));
        drive_sources();
        l0_cyc = -1;
        for (int i = 1; i < 7; i++) begin
            step();
            if (s_xfer && s_data == 16'h2000) l0_cyc = i;
            if (i < 4) begin
                checks++;
                if (s_local_ready !== 1'b0) begin failures++; $display("FAIL ilv_local_blocked cyc=%0d got=%b expected=0", i, s_local_ready); end
            end
        end
        checks++;
        if (l0_cyc != 4) begin failures++; $display("FAIL ilv_local_cycle got=%0d expected=4", l0_cyc); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL ilv_drain got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic load_single_flits(input bit strict);
        int order[12];
        int ri, li;
        order = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            rq.push_back(fl(16'h3000 + 16'(i), 1'b1, 1'b1));
            lq.push_back(fl(16'h4000 + 16'(i), 1'b1, 1'b1));
        end
        ri = 0; li = 0;
        for (int i = 0; i < 12; i++) begin
            if (strict ? (i >= 6) : (order[i] == 1)) begin
                exp_q.push_back(fl(16'h4000 + 16'(li), 1'b1, 1'b1)); li++;
            end else begin
                exp_q.push_back(fl(16'h3000 + 16'(ri), 1'b1, 1'b1)); ri++;
            end
        end
        drive_sources();
    endtask

    task automatic test_starvation_guard();
        use0 = 1'b0;
        do_reset();
        load_single_flits(1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (s_xfer !== 1'b1) begin failures++; $display("FAIL guard_xfer cyc=%0d got=%b expected=1", i, s_xfer); end
`ifdef RING_ROUTER_MUX_STATS_EN
            if (i == 5) begin
                checks++;
                if (s2_forced !== 16'd2) begin failures++; $display("FAIL guard_forced6 got=%0d expected=2", s2_forced); end
            end
`endif
        end
`ifdef RING_ROUTER_MUX_STATS_EN
        checks++;
        if (s2_forced !== 16'd3 || s2_ring !== 16'd6 || s2_local !== 16'd6) begin
            failures++;
            $display("FAIL guard_stats got=%0d/%0d/%0d expected=3/6/6", s2_forced, s2_ring, s2_local);
        end
`endif
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL guard_drain got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_strict_priority();
        use0 = 1'b1;
        do_reset();
        load_single_flits(1'b1);
        for (int i = 0; i < 12; i++) begin
            step();
            if (i < 6) begin
                checks++;
                if (s_local_ready !== 1'b0) begin failures++; $display("FAIL strict_local_ready cyc=%0d got=%b expected=0", i, s_local_ready); end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL strict_drain got=%0d expected=0", exp_q.size()); end
        use0 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic rdy[7];
        rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        use0 = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            lq.push_back(fl(16'h5000 + 16'(i), (i == 0), (i == 2)));
            exp_q.push_back(fl(16'h5000 + 16'(i), (i == 0), (i == 2)));
        end
        exp_q.push_back(fl(16'h6000, 1'b1, 1'b1));
        out_ring_ready = rdy[0];
        drive_sources();
        step();
        rq.push_back(fl(16'h6000, 1'b1, 1'b1));
        for (int i = 1; i < 7; i++) begin
            out_ring_ready = rdy[i];
            local_gap = (i == 4);
            drive_sources();
            step();
            if (i <= 5) begin
                checks++;
                if (s_ring_ready !== 1'b0) begin failures++; $display("FAIL bp_ring_blocked cyc=%0d got=%b expected=0", i, s_ring_ready); end
            end
            if (i == 4) begin
                checks++;
                if (s_out_valid !== 1'b0) begin failures++; $display("FAIL bp_bubble got=%b expected=0", s_out_valid); end
            end
            if (i == 6) begin
                checks++;
                if (s_xfer !== 1'b1 || s_data !== 16'h6000) begin
                    failures++;
                    $display("FAIL bp_ring_after got=%b/%h expected=1/6000", s_xfer, s_data);
                end
            end
        end
        local_gap = 1'b0;
        out_ring_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_worm();
        use0 = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) rq.push_back(fl(16'h7000 + 16'(i), (i == 0), (i == 4)));
        exp_q.push_back(fl(16'h7000, 1'b1, 1'b0));
        exp_q.push_back(fl(16'h7001, 1'b0, 1'b0));
        drive_sources();
        step();
        step();
        lq.push_back(fl(16'h8000, 1'b1, 1'b0));
        lq.push_back(fl(16'h8001, 1'b0, 1'b1));
        drive_sources();
        rst = 1'b1;
        #1;
        checks++;
        if (o2_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b expected=0", o2_valid); end
        checks++;
        if (r2_ring_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b expected=0", r2_ring_ready); end
        rq.delete();
        drive_sources();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(fl(16'h8000, 1'b1, 1'b0));
        exp_q.push_back(fl(16'h8001, 1'b0, 1'b1));
        step();
        checks++;
        if (s_xfer !== 1'b1 || s_data !== 16'h8000) begin
            failures++;
            $display("FAIL mid_local_first got=%b/%h expected=1/8000", s_xfer, s_data);
        end
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL mid_drain got=%0d expected=0", exp_q.size()); end
    endtask

    initial begin
        use0 = 1'b0;
        local_gap = 1'b0;
        rst = 1'b1;
        out_ring_ready = 1'b0;
        drive_sources();
        test_reset();
        test_local_only();
        test_interleave();
        test_starvation_guard();
        test_strict_priority();
        test_backpressure();
        test_reset_mid_worm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached without finishing");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ring_router_mux.md
Name: ring_router_mux

Overview:
- Output-side arbiter of a ring router station. Merges two worm streams onto the outgoing ring link: ring traffic passing through this station, and locally injected traffic.
- Sits after the station's ring input demultiplexer (pass-through branch) and the local injection port.
- Grants whole worms (first..last flit), never interleaves them, and bounds local-injection starvation with a programmable ring burst limit.

Parameters:
- MAX_RING_BURST, 4, consecutive ring worms granted while local is waiting before local is forced in; 0 = strict ring priority, no guard.
- CNT_WIDTH, 16, width of optional statistics counters.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_ring  dii_channel.slave  data[15:0]/first/last/valid, ready out  pass-through ring traffic
- in_local  dii_channel.slave  data[15:0]/first/last/valid, ready out  local injection traffic
- out_ring  dii_channel.master  data[15:0]/first/last/valid, ready in  outgoing ring link

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-high. On reset, state = IDLE, ring_streak = 0, and out_ring.valid deasserts immediately.
- Datapath: purely combinational, zero latency. out_ring.data/first/last/valid = the selected source's signals. The selected source's ready = out_ring.ready. The non-selected source's ready = 0.
- Flit transfer: valid & ready on the selected source in the same cycle.
- States: IDLE, FWD_RING, FWD_LOCAL.
- Selection in IDLE:
  - Only one source valid: select it.
  - Both valid: select ring, unless MAX_RING_BURST != 0 and ring_streak >= MAX_RING_BURST; then select local.
  - None valid: select ring (valid=0 out).
- IDLE transitions:
  - Selected source transfers a flit with last=0: go to FWD_RING or FWD_LOCAL accordingly.
  - Single-flit worm (last=1 on transfer): stay in IDLE.
  - A flit arriving in IDLE is treated as a worm head regardless of its first bit.
- FWD_x:
  - Selection is locked to source x; the other source is ignored even if valid.
  - Transfer with last=1: return to IDLE.
  - Source x valid=0 mid-worm: hold the state; out_ring.valid=0 (bubble).
  - out_ring.ready=0: hold; nothing transfers.
- ring_streak (saturating at MAX_RING_BURST):
  - Evaluated when a ring worm completes (last flit transferred):
    - in_local.valid=1 at that cycle: ring_streak += 1.
    - in_local.valid=0: ring_streak = 0.
  - Local worm completion: ring_streak = 0.
  - Width is clog2(MAX_RING_BURST+1), minimum 1.
- Grant decisions are made only in IDLE, so the starvation guard never preempts a worm in flight.
- Combinational rules:
  - No combinational path from out_ring.ready to any valid.
  - in_x.ready must not depend on in_x.valid of the same source, except via the IDLE selection.
- Reset mid-worm: the worm is truncated; the downstream receiver sees a worm without last. This is accepted system behaviour; the block returns to IDLE.

Optional Feature:
- Macro: RING_ROUTER_MUX_STATS_EN.
- Defined: adds output ports:
  - stat_ring_worms  output  CNT_WIDTH
  - stat_local_worms  output  CNT_WIDTH
  - stat_local_forced  output  CNT_WIDTH
- Counter behaviour:
  - stat_ring_worms / stat_local_worms: +1 per completed worm (last flit transferred) from that source.
  - stat_local_forced: +1 per local grant made because of the starvation guard.
  - All counters saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; arbitration is identical.

Test Plan:
- Local only: 3-flit worm 0x0005,0xAAAA,0xBBBB, out_ring.ready=1 -> appears on out_ring in cycles 0..2 unchanged; in_ring.ready=0 throughout; state back to IDLE after cycle 2.
- Interleave attempt: ring 4-flit worm starts; local becomes valid in cycle 1 -> out_ring carries all 4 ring flits contiguously; local's first flit is transferred in cycle 4.
- Starvation guard, MAX_RING_BURST=2: ring and local both continuously valid with 1-flit worms -> output order R,R,L,R,R,L; with STATS_EN, stat_local_forced=2 after 6 worms.
- Strict priority, MAX_RING_BURST=0: same stimulus as previous scenario -> only ring worms are forwarded; in_local.ready stays 0.
- Backpressure/bubble: out_ring.ready toggles 1,0,1,0 during a local 3-flit worm, and local valid drops for 1 cycle mid-worm -> no flit duplicated or lost; ring stays blocked until last transfers.
- Reset mid-worm: assert rst asynchronously after flit 2 of a ring 5-flit worm -> out_ring.valid=0 before the next edge; after release, a pending local worm is granted first.
